module_random_sampler: RTL and testbench

//  Consumer stage directly downstream of the 32-bit XNOR LFSR generator. It gates the LFSR
//  i_Enable, stirs the LFSR for a fixed number of cycles per request, then captures a

---
 rtl/module_random_sampler.sv | 126 ++++++++++++
 tb/tb_module_random_sampler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_random_sampler.sv
// Random sampler: consumer stage behind a 32-bit XNOR LFSR.
// Each request edge enables the LFSR for a fixed number of cycles and then
// captures a sample. The sample is offered on a valid/ready handshake.
// One further request can wait in a one-deep pending slot while a sample
// is still in flight.
module module_random_sampler #(
  parameter int NUM_BITS    = 32,
  parameter int OUT_BITS    = 16,
  parameter int STIR_CYCLES = 8,
  parameter int CNT_BITS    = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Req,
  input  logic [NUM_BITS-1:0] i_Lfsr_Data,
  output logic                o_Lfsr_En,
  output logic [OUT_BITS-1:0] o_Data,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic                o_Busy,
  output logic [CNT_BITS-1:0] o_Count
);

  localparam int STIR_W = (STIR_CYCLES > 1) ? $clog2(STIR_CYCLES) : 1;
  localparam logic [STIR_W-1:0] STIR_LAST = STIR_W'(STIR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STIR  = 2'd1,
    LOAD  = 2'd2,
    VALID = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STIR_W-1:0]   stirCnt_q, stirCnt_d;
  logic [OUT_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                pending_q, pending_d;
  logic                reqPrev_q;
  logic                rise;

  // The upper LFSR bits are never sampled. They are folded into this signal
  // so that the unused input bits are visible on purpose.
  logic                unusedLfsrBits;
  assign unusedLfsrBits = ^i_Lfsr_Data;

  assign rise = i_Req & ~reqPrev_q;

  // Registers for the state and the stir counter, and for the data, valid,
  // count and pending flags. Reset preloads reqPrev_q high.
  // Because of that preload, a request held high through reset does not
  // fire once reset is released.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      stirCnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      pending_q <= 1'b0;
      reqPrev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      stirCnt_q <= stirCnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      reqPrev_q <= i_Req;
    end
  end

  // Next-state logic. Any request edge that arrives while busy, and that is
  // not taken directly at acceptance, lands in the pending slot.
  always_comb begin
    state_d   = state_q;
    stirCnt_d = stirCnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    count_d   = count_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = STIR;
          stirCnt_d = '0;
        end
      end
      STIR: begin
        stirCnt_d = stirCnt_q + STIR_W'(1);
        if (stirCnt_q == STIR_LAST) state_d = LOAD;
        if (rise) pending_d = 1'b1;
      end
      LOAD: begin
        data_d  = i_Lfsr_Data[OUT_BITS-1:0];
        valid_d = 1'b1;
        state_d = VALID;
        if (rise) pending_d = 1'b1;
      end
      VALID: begin
        if (i_Ready) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_BITS'(1);
          if (pending_q || rise) begin
            state_d   = STIR;
            stirCnt_d = '0;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (rise) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_Lfsr_En = (state_q == STIR);
  assign o_Busy    = (state_q != IDLE);
  assign o_Data    = data_q;
  assign o_Valid   = valid_q;
  assign o_Count   = count_q;

endmodule

// File: tb/tb_module_random_sampler.sv
// Testbench for module_random_sampler.
// Three instances share one stimulus stream:
//   dutA uses the default parameters.
//   dutB uses STIR_CYCLES = 1.
//   dutC uses CNT_BITS = 2.
// Each instance has its own behavioural XNOR LFSR. That LFSR is reseeded by
// the shared reset and steps whenever its sampler enables it.
module tb_module_random_sampler;

  localparam logic [31:0] SEED = 32'hDA1EBEBE;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ready;

  logic [31:0] lfsrA, lfsrB, lfsrC;
  logic        enA, enB, enC;
  logic [15:0] dataA, dataB, dataC;
  logic        validA, validB, validC;
  logic        busyA, busyB, busyC;
  logic [7:0]  countA, countB;
  logic [1:0]  countC;

  int checks = 0;
  int errors = 0;
  int enEdgesA = 0;
  int enEdgesB = 0;

  module_random_sampler dutA (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Lfsr_Data(lfsrA),
    .o_Lfsr_En(enA), .o_Data(dataA), .o_Valid(validA), .i_Ready(ready),
    .o_Busy(busyA), .o_Count(countA)
  );

  module_random_sampler #(.STIR_CYCLES(1)) dutB (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Lfsr_Data(lfsrB),
    .o_Lfsr_En(enB), .o_Data(dataB), .o_Valid(validB), .i_Ready(ready),
    .o_Busy(busyB), .o_Count(countB)
  );

  module_random_sampler #(.CNT_BITS(2)) dutC (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Lfsr_Data(lfsrC),
    .o_Lfsr_En(enC), .o_Data(dataC), .o_Valid(validC), .i_Ready(ready),
    .o_Busy(busyC), .o_Count(countC)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One step of the 32-bit XNOR LFSR, using taps 32, 22, 2 and 1.
  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    logic fb;
    fb = ~(s[31] ^ s[21] ^ s[1] ^ s[0]);
    return {s[30:0], fb};
  endfunction

  // Behavioural LFSR stages, plus counters of the enabled edges.
  always @(posedge clk) begin
    if (rst) begin
      lfsrA <= SEED;
      lfsrB <= SEED;
      lfsrC <= SEED;
    end else begin
      if (enA) lfsrA <= lfsrStep(lfsrA);
      if (enB) lfsrB <= lfsrStep(lfsrB);
      if (enC) lfsrC <= lfsrStep(lfsrC);
    end
    if (enA) enEdgesA <= enEdgesA + 1;
    if (enB) enEdgesB <= enEdgesB + 1;
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic reqIn, input logic readyIn, input logic rstIn);
    req   = reqIn;
    ready = readyIn;
    rst   = rstIn;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitValidA(input logic readyIn, input int bound, output logic seen);
    int n;
    n = 0;
    while (!validA && n < bound) begin
      applyStimulus(1'b0, readyIn, 1'b0);
      n++;
    end
    seen = validA;
  endtask

  logic [15:0] golden8;
  logic [15:0] heldData;
  logic        seen;
  int          e0;
  int          validCnt;
  int          firstIdx;
  logic [15:0] firstData;
  logic [1:0]  expCountC [5];

  initial begin
    logic [31:0] g;
    g = SEED;
    repeat (8) g = lfsrStep(g);
    golden8 = g[15:0];
    expCountC[0] = 2'd1;
    expCountC[1] = 2'd2;
    expCountC[2] = 2'd3;
    expCountC[3] = 2'd0;
    expCountC[4] = 2'd1;

    req = 1'b0;
    ready = 1'b0;
    rst = 1'b1;

    // Reset state.
    doReset();
    checkOutput("rst valid", {31'd0, validA}, 32'd0);
    checkOutput("rst data", {16'd0, dataA}, 32'd0);
    checkOutput("rst count", {24'd0, countA}, 32'd0);
    checkOutput("rst busy", {31'd0, busyA}, 32'd0);
    checkOutput("rst en", {31'd0, enA}, 32'd0);

    // T1: STIR_CYCLES = 1. A single enabled edge, then capture 16'h7D7D.
    e0 = enEdgesB;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("T1 busy", {31'd0, busyB}, 32'd1);
    checkOutput("T1 en on", {31'd0, enB}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T1 en off", {31'd0, enB}, 32'd0);
    checkOutput("T1 valid early", {31'd0, validB}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T1 valid", {31'd0, validB}, 32'd1);
    checkOutput("T1 data", {16'd0, dataB}, 32'h7D7D);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T1 valid drop", {31'd0, validB}, 32'd0);
    checkOutput("T1 count", {24'd0, countB}, 32'd1);
    checkOutput("T1 en edges", enEdgesB - e0, 32'd1);
    checkOutput("T1 data hold", {16'd0, dataB}, 32'h7D7D);

    // T2: request held high for 100 cycles. Exactly one sample, after edge k+9.
    doReset();
    e0 = enEdgesA;
    validCnt = 0;
    firstIdx = -1;
    firstData = '0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (validA) begin
        validCnt++;
        if (firstIdx < 0) begin
          firstIdx = i;
          firstData = dataA;
        end
      end
    end
    checkOutput("T2 sample count", validCnt, 32'd1);
    checkOutput("T2 latency", firstIdx, 32'd9);
    checkOutput("T2 data", {16'd0, firstData}, {16'd0, golden8});
    checkOutput("T2 en edges", enEdgesA - e0, 32'd8);
    checkOutput("T2 count", {24'd0, countA}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // T3: consumer stalls for 20 cycles, then accepts.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValidA(1'b0, 20, seen);
    checkOutput("T3 valid seen", {31'd0, seen}, 32'd1);
    heldData = dataA;
    checkOutput("T3 data", {16'd0, heldData}, {16'd0, golden8});
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("T3 stall valid", {31'd0, validA}, 32'd1);
      checkOutput("T3 stall data", {16'd0, dataA}, {16'd0, heldData});
      checkOutput("T3 stall en", {31'd0, enA}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T3 accept valid", {31'd0, validA}, 32'd0);
    checkOutput("T3 accept count", {24'd0, countA}, 32'd1);
    checkOutput("T3 data retained", {16'd0, dataA}, {16'd0, heldData});
    checkOutput("T3 idle", {31'd0, busyA}, 32'd0);

    // T4: three request edges while busy. Only one is kept as pending.
    doReset();
    e0 = enEdgesA;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValidA(1'b0, 20, seen);
    checkOutput("T4 valid seen", {31'd0, seen}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T4 accept valid", {31'd0, validA}, 32'd0);
    checkOutput("T4 restir busy", {31'd0, busyA}, 32'd1);
    checkOutput("T4 restir en", {31'd0, enA}, 32'd1);
    checkOutput("T4 count1", {24'd0, countA}, 32'd1);
    validCnt = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (validA) validCnt++;
    end
    checkOutput("T4 second sample", validCnt, 32'd1);
    checkOutput("T4 count2", {24'd0, countA}, 32'd2);
    checkOutput("T4 idle", {31'd0, busyA}, 32'd0);
    checkOutput("T4 en edges", enEdgesA - e0, 32'd16);

    // T5: reset mid-stir while the request is held high.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitValidA(1'b1, 20, seen);
    checkOutput("T5 valid seen", {31'd0, seen}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("T5 pre count", {24'd0, countA}, 32'd1);
    checkOutput("T5 pre data", {16'd0, dataA}, {16'd0, golden8});
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("T5 mid stir", {31'd0, enA}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    e0 = enEdgesA;
    checkOutput("T5 rst valid", {31'd0, validA}, 32'd0);
    checkOutput("T5 rst data", {16'd0, dataA}, 32'd0);
    checkOutput("T5 rst count", {24'd0, countA}, 32'd0);
    checkOutput("T5 rst busy", {31'd0, busyA}, 32'd0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("T5 no fire busy", {31'd0, busyA}, 32'd0);
    checkOutput("T5 no fire en", enEdgesA - e0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("T5 refire busy", {31'd0, busyA}, 32'd1);
    checkOutput("T5 refire en", {31'd0, enA}, 32'd1);

    // T6: the 2-bit counter wraps after 3 and reads 1,2,3,0,1.
    doReset();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("T6 count wrap", {30'd0, countC}, {30'd0, expCountC[n]});
      checkOutput("T6 count wide", {24'd0, countA}, n + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
